// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated channel mux.
// Imported by the arbiter and the top-level datapath.
package mux_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  // Ceiling log2, with a floor of 1 so a 1-bit index always exists.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index wins) or
// round robin searching upward from ptr with wrap-around.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic                mode_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] gnt_o,
  output logic [SEL_W-1:0]    idx_o
);

  // Scan candidates from last to first so the earliest
  // position in search order is the one that sticks.
  always_comb begin
    logic [SEL_W-1:0] j;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (mode_i)
        j = SEL_W'((int'(ptr_i) + k) % CHANNELS);
      else
        j = SEL_W'(k);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated mux with a single registered output slot.
// One-cycle latency, full throughput when downstream is ready.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic [CHANNELS-1:0] gnt;
  logic [SEL_W-1:0]    idx;
  logic                free;
  logic                grant;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req_i  (in_valid),
    .mode_i (mode),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (idx)
  );

  // Accept only when the output slot can take a word and not in reset.
  always_comb begin
    free     = !valid_q || out_ready;
    in_ready = (rst_n && free) ? gnt : '0;
    grant    = |in_ready;
  end

  // Next state: load on grant, drain when consumed, else hold.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (grant) begin
      data_d  = in_data[idx*WIDTH +: WIDTH];
      sel_d   = idx;
      valid_d = 1'b1;
      if (mode) begin
        if (idx == SEL_W'(CHANNELS - 1))
          ptr_d = '0;
        else
          ptr_d = idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output slot and round-robin pointer; reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (4 channels, 8 bits):
// vector table plus hand-written multi-cycle sequences.
module tb_arb_mux;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int total;
  int bad;

  arb_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [7:0] e_data;
    logic [1:0] e_sel;
    logic [1:0] e_ptr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov,
                         input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"}, 32'(out_data), 32'(d));
    chk({tag, ".out_sel"}, 32'(out_sel), 32'(s));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // ch3=33 ch2=22 ch1=11 ch0=A0
    in_data   = 32'h3322_11A0;
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // mode valid ordy | e_rdy ov data sel ptr
    tbl[0] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 2'd0};
    tbl[1] = '{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2, 2'd0};
    tbl[2] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd2, 2'd0};
    tbl[3] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h33, 2'd3, 2'd0};
    tbl[4] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd3, 2'd0};
    tbl[5] = '{1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 2'd2};
    tbl[6] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 2'd1};
    tbl[7] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3, 2'd0};
    tbl[8] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 2'd0};
    tbl[9] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 2'd1};

    // Reset with every channel offering.
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    step();
    chk("rst.in_ready2", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.ptr", 32'(dut.ptr_q), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      mode      = tbl[i].mode;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready),
          32'(tbl[i].e_rdy));
      step();
      chk_out($sformatf("v%0d", i), tbl[i].e_ov, tbl[i].e_data,
              tbl[i].e_sel);
      chk($sformatf("v%0d.ptr", i), 32'(dut.ptr_q),
          32'(tbl[i].e_ptr));
    end

    // Backpressure: bring up sel=2 via round robin (ptr=1).
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    chk_out("bp.pre1", 1'b1, 8'h11, 2'd1);
    step();
    chk_out("bp.pre2", 1'b1, 8'h22, 2'd2);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'h0);
      step();
      chk_out($sformatf("bp%0d", c), 1'b1, 8'h22, 2'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rel.in_ready", 32'(in_ready), 32'b1000);
    step();
    chk_out("bp.rel", 1'b1, 8'h33, 2'd3);

    // Mid-operation reset while the slot is stalled and full.
    in_valid  = 4'b0110;
    step();
    out_ready = 1'b0;
    chk_out("mr.pre", 1'b1, 8'h11, 2'd1);
    chk("mr.pre.ptr", 32'(dut.ptr_q), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mr.in_ready", 32'(in_ready), 32'h0);
    step();
    chk_out("mr", 1'b0, 8'h00, 2'd0);
    chk("mr.ptr", 32'(dut.ptr_q), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Round-robin fairness from ptr=0 over 8 cycles.
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d.in_ready", k), 32'(in_ready),
          32'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr%0d.out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("rr%0d.out_sel", k), 32'(out_sel), 32'(k % 4));
    end

    // Idle drain, then immediate re-grant.
    in_valid = 4'b0000;
    step();
    chk_out("idle", 1'b0, 8'h33, 2'd3);
    chk("idle.ptr", 32'(dut.ptr_q), 32'd0);
    in_valid = 4'b0001;
    #1;
    chk("idle.regrant.in_ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("idle.regrant", 1'b1, 8'hA0, 2'd0);
    chk("idle.regrant.ptr", 32'(dut.ptr_q), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of input channels, legal range 2..8.
REQ-003 The block SHALL have local constant SEL_W = clog2(CHANNELS), meaning the grant index width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have port mode, input, 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round robin.
REQ-007 The block SHALL have port in_data, input, CHANNELS*WIDTH, channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_valid, input, CHANNELS, per-channel offer.
REQ-009 The block SHALL have port in_ready, output, CHANNELS, per-channel accept; combinational.
REQ-010 The block SHALL have port out_data, output, WIDTH, registered selected data.
REQ-011 The block SHALL have port out_sel, output, SEL_W, registered index of the channel that supplied out_data.
REQ-012 The block SHALL have port out_valid, output, 1, registered output offer.
REQ-013 The block SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 A transfer on any port SHALL occur only on a rising edge where that port's valid and ready are both 1.
REQ-015 Output slot "free" SHALL be defined as (out_valid == 0) or (out_ready == 1).
REQ-016 When the slot is free and at least one in_valid bit is 1, exactly one in_ready bit SHALL be 1: the granted channel's bit.
REQ-017 In all other cases all in_ready bits SHALL be 0, and in_ready SHALL never depend on in_data.
REQ-018 With mode = 0, the grant SHALL go to the lowest-index valid channel.
REQ-019 With mode = 1, the grant SHALL go to the first valid channel searching upward from pointer ptr, wrapping from CHANNELS-1 to 0.
REQ-020 After a round-robin grant to channel g, ptr SHALL become g+1, wrapping to 0 when g = CHANNELS-1.
REQ-021 ptr SHALL be unchanged in cycles with no grant and in all cycles with mode = 0.
REQ-022 On a grant, the block SHALL load out_data, out_sel and out_valid = 1 on the same edge: one-cycle latency.
REQ-023 The block SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-024 When out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL hold stable.
REQ-025 When out_ready = 1 and there is no grant, out_valid SHALL go to 0 on the next edge, and out_data and out_sel SHALL hold their last values.
REQ-026 A change of mode SHALL affect only grants decided after it is sampled; no in-flight data SHALL be lost or duplicated.

Reset
REQ-027 While rst_n = 0 at a rising edge, the block SHALL set out_valid = 0, out_data = 0, out_sel = 0 and ptr = 0.
REQ-028 During reset, in_ready SHALL be all 0.
REQ-029 A word held in the output register when reset is asserted mid-operation SHALL be discarded.
REQ-030 On the first edge with rst_n = 1, the block SHALL operate normally.

Structure
REQ-031 Shared package mux_pkg SHALL provide the clog2 function and the default WIDTH and CHANNELS constants.
REQ-032 Arbitration SHALL be a sub-module rr_arbiter with the following interface: request vector, mode and ptr in; one-hot grant and index out; purely combinational.
REQ-033 The datapath selection SHALL be an indexed part-select on in_data, and the top level SHALL hold all registers.

Verification (CHANNELS=4, WIDTH=8)
REQ-034 Reset check: assert rst_n = 0 with all in_valid = 1 -> out_valid = 0, out_data = 0x00, out_sel = 0, in_ready = 4'b0000.
REQ-035 Fixed priority: mode = 0, in_valid = 4'b1010, data ch1 = 0x11, ch3 = 0x33, out_ready = 1 -> in_ready = 4'b0010; next cycle out_data = 0x11 and out_sel = 1.
REQ-036 Round robin fairness: mode = 1, in_valid = 4'b1111 held for 8 cycles, out_ready = 1 -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid = 1 throughout.
REQ-037 Backpressure: with out_valid = 1 and out_sel = 2, hold out_ready = 0 for 3 cycles -> in_ready = 0, and out_data/out_sel stay stable; on release, the next grant is ch3.
REQ-038 Idle drain: in_valid = 0 and out_ready = 1 -> out_valid falls next cycle and ptr is unchanged; then in_valid = 4'b0001 -> grant ch0 with no stall.
REQ-039 Mid-operation reset: with out_valid = 1 and out_ready = 0, pulse rst_n low for 1 cycle -> out_valid = 0 and ptr = 0; the next round-robin grant starts from ch0.
